// File: rtl/sa_pkg.sv
// Shared constants and helpers for the systolic matrix multiplier.
package sa_pkg;

    // Width of a counter that must be able to hold every value 0..len inclusive.
    function automatic int cnt_width(input int len);
        return (len < 1) ? 1 : $clog2(len + 1);
    endfunction

endpackage

// File: rtl/systolic_pe.sv
// One processing element: an unsigned multiply-accumulate cell that also
// forwards its A operand rightwards and its B operand downwards.
module systolic_pe #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] a_in,
    input  logic [DATA_WIDTH-1:0] b_in,
    output logic [DATA_WIDTH-1:0] a_out,
    output logic [DATA_WIDTH-1:0] b_out,
    output logic [DATA_WIDTH-1:0] acc
);

    logic [DATA_WIDTH-1:0] acc_reg;
    logic [DATA_WIDTH-1:0] a_fwd_reg;
    logic [DATA_WIDTH-1:0] b_fwd_reg;
    logic [DATA_WIDTH-1:0] prod;

    // Product kept at operand width: arithmetic wraps modulo 2^DATA_WIDTH.
    assign prod = a_in * b_in;

    // Accumulate and forward operands on every enabled edge; hold otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_reg   <= '0;
            a_fwd_reg <= '0;
            b_fwd_reg <= '0;
        end else if (en) begin
            acc_reg   <= acc_reg + prod;
            a_fwd_reg <= a_in;
            b_fwd_reg <= b_in;
        end
    end

    assign a_out = a_fwd_reg;
    assign b_out = b_fwd_reg;
    assign acc   = acc_reg;

endmodule

// File: rtl/systolic_array.sv
// Output-stationary MxN systolic multiplier. A rows stream in from the left,
// B columns from the top, both taken last-index-first from the held images;
// each PE(i,j) accumulates element P[i][j] in place.
module systolic_array
    import sa_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int M          = 2,
    parameter int N          = 3,
    parameter int L          = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] a [M][L],
    input  logic [DATA_WIDTH-1:0] b [L][N],
    output logic [DATA_WIDTH-1:0] P [M][N]
);

    localparam int CW = cnt_width(L);

    logic [CW-1:0]         k_reg;
    logic [DATA_WIDTH-1:0] row_feed [M];
    logic [DATA_WIDTH-1:0] col_feed [N];
    logic [DATA_WIDTH-1:0] a_link   [M][N];
    logic [DATA_WIDTH-1:0] b_link   [M][N];

    // Feed counter: steps once per enabled edge and parks at L, after which the edges see zeros.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            k_reg <= '0;
        end else if (en && (k_reg < CW'(L))) begin
            k_reg <= k_reg + 1'b1;
        end
    end

    // Edge multiplexing: element L-1-k of each stream, zero once the counter has parked.
    always_comb begin
        for (int i = 0; i < M; i++) begin
            row_feed[i] = '0;
            for (int l = 0; l < L; l++) begin
                if (k_reg == CW'(l)) begin
                    row_feed[i] = a[i][L-1-l];
                end
            end
        end
        for (int j = 0; j < N; j++) begin
            col_feed[j] = '0;
            for (int l = 0; l < L; l++) begin
                if (k_reg == CW'(l)) begin
                    col_feed[j] = b[L-1-l][j];
                end
            end
        end
    end

    genvar gi, gj;
    generate
        for (gi = 0; gi < M; gi++) begin : g_row
            for (gj = 0; gj < N; gj++) begin : g_col
                logic [DATA_WIDTH-1:0] a_src;
                logic [DATA_WIDTH-1:0] b_src;
                logic [DATA_WIDTH-1:0] acc_w;

                if (gj == 0) begin : g_a_edge
                    assign a_src = row_feed[gi];
                end else begin : g_a_chain
                    assign a_src = a_link[gi][gj-1];
                end

                if (gi == 0) begin : g_b_edge
                    assign b_src = col_feed[gj];
                end else begin : g_b_chain
                    assign b_src = b_link[gi-1][gj];
                end

                systolic_pe #(
                    .DATA_WIDTH(DATA_WIDTH)
                ) u_pe (
                    .clk   (clk),
                    .reset (reset),
                    .en    (en),
                    .a_in  (a_src),
                    .b_in  (b_src),
                    .a_out (a_link[gi][gj]),
                    .b_out (b_link[gi][gj]),
                    .acc   (acc_w)
                );

                assign P[gi][gj] = acc_w;
            end
        end
    endgenerate

endmodule

// File: tb/tb_systolic_array.sv
// Self-checking bench for systolic_array: a behavioural model computes each
// P element as a time-aligned dot product of the two feed streams; a compare
// process checks the default-size array on every falling edge, and directed
// phases add hand-computed literal expectations.
module tb_systolic_array;

    localparam int DW = 8;
    localparam int M  = 2;
    localparam int N  = 3;
    localparam int L  = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          en;
    logic [DW-1:0] a [M][L];
    logic [DW-1:0] b [L][N];
    logic [DW-1:0] P [M][N];

    // Small 2x2 instance for the identity case (stream length 3 so row 1 can be skewed).
    logic          reset2;
    logic          en2;
    logic [DW-1:0] a2 [2][3];
    logic [DW-1:0] b2 [3][2];
    logic [DW-1:0] p2 [2][2];

    int  checks = 0;
    int  errors = 0;
    int  n_edges = 0;
    bit  chk_on = 1'b0;

    logic [DW-1:0] gold [M][N];

    systolic_array #(.DATA_WIDTH(DW), .M(M), .N(N), .L(L)) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .a     (a),
        .b     (b),
        .P     (P)
    );

    systolic_array #(.DATA_WIDTH(DW), .M(2), .N(2), .L(3)) dut2 (
        .clk   (clk),
        .reset (reset2),
        .en    (en2),
        .a     (a2),
        .b     (b2),
        .P     (p2)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    // Stream seen at the left edge of row i at feed step k.
    function automatic logic [DW-1:0] feed_a(input int i, input int k);
        if (k < 0 || k >= L) return '0;
        return a[i][L-1-k];
    endfunction

    // Stream seen at the top edge of column j at feed step k.
    function automatic logic [DW-1:0] feed_b(input int j, input int k);
        if (k < 0 || k >= L) return '0;
        return b[L-1-k][j];
    endfunction

    // P[i][j] after n enabled edges: row stream arrives j steps late, column stream i steps late.
    function automatic logic [DW-1:0] model_p(input int i, input int j, input int n);
        logic [DW-1:0] s;
        s = '0;
        for (int t = 0; t < n; t++) begin
            s = s + DW'(feed_a(i, t - j) * feed_b(j, t - i));
        end
        return s;
    endfunction

    // Enabled-edge count since the last reset, the model's notion of time.
    always @(posedge clk or negedge reset) begin
        if (!reset) n_edges <= 0;
        else if (en) n_edges <= n_edges + 1;
    end

    // Compare process: every falling edge, every P element against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < M; i++) begin
                for (int j = 0; j < N; j++) begin
                    check($sformatf("model_P[%0d][%0d]@%0d", i, j, n_edges),
                          32'(P[i][j]), 32'(model_p(i, j, n_edges)));
                end
            end
        end
    end

    // Pass n rising edges and settle just after the following falling edge.
    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic load_golden();
        a = '{'{8'd0, 8'd0, 8'd0, 8'd1, 8'd3, 8'd2},
              '{8'd0, 8'd0, 8'd1, 8'd2, 8'd3, 8'd0}};
        b = '{'{8'd0, 8'd0, 8'd0}, '{8'd0, 8'd0, 8'd2}, '{8'd0, 8'd3, 8'd2},
              '{8'd1, 8'd2, 8'd1}, '{8'd2, 8'd1, 8'd0}, '{8'd3, 8'd0, 8'd0}};
    endtask

    task automatic load_zero();
        for (int i = 0; i < M; i++) for (int l = 0; l < L; l++) a[i][l] = '0;
        for (int l = 0; l < L; l++) for (int j = 0; j < N; j++) b[l][j] = '0;
    endtask

    task automatic check_gold(input string tag);
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++)
                check($sformatf("%s_P[%0d][%0d]", tag, i, j), 32'(P[i][j]), 32'(gold[i][j]));
    endtask

    task automatic check_zero(input string tag);
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++)
                check($sformatf("%s_P[%0d][%0d]", tag, i, j), 32'(P[i][j]), 32'd0);
    endtask

    task automatic show(input string tag);
        $display("%s: P = {%0d %0d %0d} {%0d %0d %0d} after %0d enabled edges", tag,
                 P[0][0], P[0][1], P[0][2], P[1][0], P[1][1], P[1][2], n_edges);
    endtask

    // Hold reset low between runs; inputs only change while reset is asserted.
    task automatic restart();
        reset = 1'b0;
        en    = 1'b0;
        edges(1);
    endtask

    initial begin
        gold = '{'{8'd13, 8'd11, 8'd10}, '{8'd14, 8'd10, 8'd9}};
        reset  = 1'b1;
        reset2 = 1'b1;
        en     = 1'b0;
        en2    = 1'b0;
        load_golden();
        for (int i = 0; i < 2; i++) for (int l = 0; l < 3; l++) a2[i][l] = '0;
        for (int l = 0; l < 3; l++) for (int j = 0; j < 2; j++) b2[l][j] = '0;
        #1;
        reset  = 1'b0;
        reset2 = 1'b0;
        edges(2);
        chk_on = 1'b1;

        // Reset state.
        check_zero("reset");
        show("reset");

        // Golden run: 9 enabled edges, then 20 more with no change.
        reset = 1'b1;
        en    = 1'b1;
        edges(9);
        check_gold("golden9");
        show("golden");
        edges(20);
        check_gold("golden29");
        show("golden_hold");

        // Enable gap of 5 cycles after edge 4.
        restart();
        load_golden();
        reset = 1'b1;
        en    = 1'b1;
        edges(4);
        en = 1'b0;
        edges(5);
        check($sformatf("gap_edges"), 32'(n_edges), 32'd4);
        en = 1'b1;
        edges(5);
        check_gold("gap");
        show("en_gap");

        // Asynchronous reset in the middle of a run, then a clean rerun.
        restart();
        load_golden();
        reset = 1'b1;
        en    = 1'b1;
        edges(5);
        reset = 1'b0;
        #1;
        check_zero("async_rst");
        show("mid_reset");
        edges(1);
        reset = 1'b1;
        edges(9);
        check_gold("rerun");
        show("rerun");

        // Wrap-around: 16*17 = 272 -> 16.
        restart();
        load_zero();
        a[0][5] = 8'd16;
        b[5][0] = 8'd17;
        reset = 1'b1;
        en    = 1'b1;
        edges(9);
        check("wrap_P[0][0]", 32'(P[0][0]), 32'd16);
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++)
                if (i != 0 || j != 0)
                    check($sformatf("wrap_P[%0d][%0d]", i, j), 32'(P[i][j]), 32'd0);
        show("wrap");

        // All-zero images.
        restart();
        load_zero();
        reset = 1'b1;
        en    = 1'b1;
        edges(15);
        check_zero("zeros");
        show("zeros");

        // Identity on the 2x2 instance: A = I, B = {{5,6},{7,8}}, rows/columns pre-skewed.
        a2 = '{'{8'd0, 8'd0, 8'd1}, '{8'd1, 8'd0, 8'd0}};
        b2 = '{'{8'd0, 8'd8}, '{8'd7, 8'd6}, '{8'd5, 8'd0}};
        reset2 = 1'b1;
        en2    = 1'b1;
        edges(4);
        check("ident4_P[0][0]", 32'(p2[0][0]), 32'd5);
        check("ident4_P[0][1]", 32'(p2[0][1]), 32'd6);
        check("ident4_P[1][0]", 32'(p2[1][0]), 32'd7);
        check("ident4_P[1][1]", 32'(p2[1][1]), 32'd8);
        edges(3);
        check("ident7_P[0][0]", 32'(p2[0][0]), 32'd5);
        check("ident7_P[0][1]", 32'(p2[0][1]), 32'd6);
        check("ident7_P[1][0]", 32'(p2[1][0]), 32'd7);
        check("ident7_P[1][1]", 32'(p2[1][1]), 32'd8);
        $display("identity: P = {%0d %0d} {%0d %0d}", p2[0][0], p2[0][1], p2[1][0], p2[1][1]);

        chk_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
